// File: rtl/audio_mix_sched_if.sv
// Valid/ready handshake bundle carrying one signed stereo sample from each producer.
interface audio_mix_sched_if;
    logic        pcm_valid;
    logic        pcm_ready;
    logic [15:0] pcm_left;
    logic [15:0] pcm_right;
    logic        psg_valid;
    logic        psg_ready;
    logic [15:0] psg_left;
    logic [15:0] psg_right;

    modport master (
        output pcm_valid, pcm_left, pcm_right,
        output psg_valid, psg_left, psg_right,
        input  pcm_ready, psg_ready
    );

    modport slave (
        input  pcm_valid, pcm_left, pcm_right,
        input  psg_valid, psg_left, psg_right,
        output pcm_ready, psg_ready
    );
endinterface

// File: rtl/audio_mix_sched.sv
// Per-frame sample scheduler: collects one stereo sample from PCM and PSG with a
// bounded wait, attenuates, sums, and holds a 24-bit stereo word for the DAC.
module audio_mix_sched #(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 next_sample,
    audio_mix_sched_if.slave     src,
    input  logic [3:0]           pcm_vol,
    input  logic [3:0]           psg_vol,
    input  logic                 clr_status,
    output logic [23:0]          left_data,
    output logic [23:0]          right_data,
    output logic                 sample_done,
    output logic                 underrun_pcm,
    output logic                 underrun_psg,
    output logic                 overrun
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        MIX     = 2'd2
    } state_e;

    state_e        state_q;
    logic          pcm_rdy_q, psg_rdy_q;
    logic          pcm_got_q, psg_got_q;
    logic          abort_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   pcm_l_q, pcm_r_q, psg_l_q, psg_r_q;
    logic [23:0]   left_q, right_q;
    logic          done_q;
    logic          upcm_q, upsg_q, ovr_q;

    logic          pcm_xfer, psg_xfer;
    logic          pcm_have, psg_have;
    logic          ovr_set, upcm_set, upsg_set;
    logic [15:0]   pcm_l_eff, pcm_r_eff, psg_l_eff, psg_r_eff;
    logic [23:0]   mix_l, mix_r;

    // vol 15 mutes; otherwise an arithmetic shift, so negatives round toward -inf.
    function automatic logic [15:0] atten(input logic [15:0] s, input logic [3:0] v);
        if (v == 4'd15) return 16'd0;
        return 16'($signed(s) >>> v);
    endfunction

    // 17-bit sum of two 16-bit signed values cannot overflow; scale into 24 bits.
    function automatic logic [23:0] mix(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        return {sum, 7'd0};
    endfunction

    assign pcm_xfer = src.pcm_valid & pcm_rdy_q;
    assign psg_xfer = src.psg_valid & psg_rdy_q;
    assign pcm_have = pcm_got_q | pcm_xfer;
    assign psg_have = psg_got_q | psg_xfer;

    // An uncaptured source contributes silence.
    assign pcm_l_eff = pcm_got_q ? atten(pcm_l_q, pcm_vol) : 16'd0;
    assign pcm_r_eff = pcm_got_q ? atten(pcm_r_q, pcm_vol) : 16'd0;
    assign psg_l_eff = psg_got_q ? atten(psg_l_q, psg_vol) : 16'd0;
    assign psg_r_eff = psg_got_q ? atten(psg_r_q, psg_vol) : 16'd0;
    assign mix_l     = mix(pcm_l_eff, psg_l_eff);
    assign mix_r     = mix(pcm_r_eff, psg_r_eff);

    assign ovr_set  = next_sample && (state_q != IDLE);
    assign upcm_set = (state_q == MIX) && !abort_q && !pcm_got_q;
    assign upsg_set = (state_q == MIX) && !abort_q && !psg_got_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pcm_rdy_q <= 1'b0;
            psg_rdy_q <= 1'b0;
            pcm_got_q <= 1'b0;
            psg_got_q <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            pcm_l_q   <= '0;
            pcm_r_q   <= '0;
            psg_l_q   <= '0;
            psg_r_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            done_q    <= 1'b0;
            upcm_q    <= 1'b0;
            upsg_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Sticky flags: a set in the same cycle as clr_status wins.
            ovr_q  <= ovr_set  | (ovr_q  & ~clr_status);
            upcm_q <= upcm_set | (upcm_q & ~clr_status);
            upsg_q <= upsg_set | (upsg_q & ~clr_status);

            case (state_q)
                IDLE: begin
                    if (next_sample) begin
                        if (enable) begin
                            state_q   <= COLLECT;
                            pcm_rdy_q <= 1'b1;
                            psg_rdy_q <= 1'b1;
                            pcm_got_q <= 1'b0;
                            psg_got_q <= 1'b0;
                            abort_q   <= 1'b0;
                            cnt_q     <= CW'(1);
                        end else begin
                            left_q  <= '0;
                            right_q <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (pcm_xfer) begin
                        pcm_l_q   <= src.pcm_left;
                        pcm_r_q   <= src.pcm_right;
                        pcm_got_q <= 1'b1;
                        pcm_rdy_q <= 1'b0;
                    end
                    if (psg_xfer) begin
                        psg_l_q   <= src.psg_left;
                        psg_r_q   <= src.psg_right;
                        psg_got_q <= 1'b1;
                        psg_rdy_q <= 1'b0;
                    end
                    if (!enable) begin
                        state_q   <= MIX;
                        abort_q   <= 1'b1;
                        pcm_rdy_q <= 1'b0;
                        psg_rdy_q <= 1'b0;
                    end else if ((pcm_have && psg_have) || (cnt_q == CW'(TIMEOUT))) begin
                        state_q   <= MIX;
                        pcm_rdy_q <= 1'b0;
                        psg_rdy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                MIX: begin
                    left_q    <= (abort_q || !enable) ? 24'd0 : mix_l;
                    right_q   <= (abort_q || !enable) ? 24'd0 : mix_r;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    pcm_got_q <= 1'b0;
                    psg_got_q <= 1'b0;
                    abort_q   <= 1'b0;
                end

                default: begin
                    state_q   <= IDLE;
                    pcm_rdy_q <= 1'b0;
                    psg_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign src.pcm_ready = pcm_rdy_q;
    assign src.psg_ready = psg_rdy_q;
    assign left_data     = left_q;
    assign right_data    = right_q;
    assign sample_done   = done_q;
    assign underrun_pcm  = upcm_q;
    assign underrun_psg  = upsg_q;
    assign overrun       = ovr_q;
endmodule

// File: tb/tb_audio_mix_sched.sv
// Randomized scoreboard bench for audio_mix_sched: periods are issued with a model
// of expected mix, flags and completion cycle; a monitor checks each sample_done.
module tb_audio_mix_sched;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic        next_sample = 1'b0;
    logic [3:0]  pcm_vol = 4'd0;
    logic [3:0]  psg_vol = 4'd0;
    logic        clr_status = 1'b0;
    logic [23:0] left_data, right_data;
    logic        sample_done, underrun_pcm, underrun_psg, overrun;

    audio_mix_sched_if ifc ();

    audio_mix_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .next_sample  (next_sample),
        .src          (ifc),
        .pcm_vol      (pcm_vol),
        .psg_vol      (psg_vol),
        .clr_status   (clr_status),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_done  (sample_done),
        .underrun_pcm (underrun_pcm),
        .underrun_psg (underrun_psg),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        bit          upcm;
        bit          upsg;
        bit          ovr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference attenuation: floor(s / 2^v), mute at 15.
    function automatic int att(input logic [15:0] x, input logic [3:0] v);
        int s, p, q;
        if (v == 4'd15) return 0;
        s = int'($signed(x));
        p = 1 << v;
        q = s / p;
        if ((s % p) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    always @(negedge clk) begin
        if (rst_n && sample_done) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk(left_data == mon_e.l, "left_data", left_data, mon_e.l);
                chk(right_data == mon_e.r, "right_data", right_data, mon_e.r);
                chk(underrun_pcm == mon_e.upcm, "underrun_pcm", underrun_pcm, mon_e.upcm);
                chk(underrun_psg == mon_e.upsg, "underrun_psg", underrun_psg, mon_e.upsg);
                chk(overrun == mon_e.ovr, "overrun", overrun, mon_e.ovr);
                chk(cyc == mon_e.cyc, "done_cycle", cyc, mon_e.cyc);
                chk(!ifc.pcm_ready && !ifc.psg_ready, "ready_after_mix",
                    {ifc.pcm_ready, ifc.psg_ready}, 0);
            end
        end
    end

    function automatic bit rdy(input bit sel);
        return sel ? ifc.psg_ready : ifc.pcm_ready;
    endfunction

    task automatic set_src(input bit sel, input bit v, input logic [15:0] l, input logic [15:0] r);
        if (sel) begin
            ifc.psg_valid = v; ifc.psg_left = l; ifc.psg_right = r;
        end else begin
            ifc.pcm_valid = v; ifc.pcm_left = l; ifc.pcm_right = r;
        end
    endtask

    // Producer: raises valid d cycles into COLLECT, holds it until accepted.
    task automatic drv_src(input bit sel, input int d, input logic [15:0] l,
                           input logic [15:0] r, input bit expect_rdy);
        int k;
        if (d > TIMEOUT + 3) return;
        repeat (d) @(negedge clk);
        set_src(sel, 1'b1, l, r);
        if (expect_rdy) begin
            chk(rdy(sel), sel ? "psg_ready_high" : "pcm_ready_high", rdy(sel), 1);
            k = 0;
            while (!rdy(sel) && k < TIMEOUT + 4) begin
                @(negedge clk);
                k++;
            end
            if (rdy(sel)) begin
                @(negedge clk);
                chk(!rdy(sel), sel ? "psg_ready_drop" : "pcm_ready_drop", rdy(sel), 0);
            end
        end else begin
            repeat (3) begin
                chk(!rdy(sel), sel ? "psg_ready_idle" : "pcm_ready_idle", rdy(sel), 0);
                @(negedge clk);
            end
        end
        set_src(sel, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < TIMEOUT + 12) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            chk(1'b0, "done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // One frame: dp/ds = cycles after COLLECT entry that each source turns valid
    // (beyond TIMEOUT+3 means never); ab = enable drop offset; xo = extra pulse offset.
    task automatic period(input bit en, input int dp, input int ds,
                          input logic [15:0] pl, input logic [15:0] pr,
                          input logic [15:0] sl, input logic [15:0] sr,
                          input logic [3:0] pv, input logic [3:0] sv,
                          input int ab, input int xo_in);
        int m, xo, ap_l, ap_r, as_l, as_r;
        bit cp, cs, aborted;
        exp_t e;
        cp = dp < TIMEOUT;
        cs = ds < TIMEOUT;
        m = (cp && cs) ? 2 + ((dp > ds) ? dp : ds) : TIMEOUT + 1;
        aborted = (ab >= 0) && (ab <= m - 2);
        if (aborted) m = ab + 2;
        xo = (xo_in > m - 1) ? -1 : xo_in;
        if (!en) begin
            e.l = 24'd0; e.r = 24'd0; e.upcm = 0; e.upsg = 0; e.ovr = 0;
        end else begin
            ap_l = (cp && !aborted) ? att(pl, pv) : 0;
            ap_r = (cp && !aborted) ? att(pr, pv) : 0;
            as_l = (cs && !aborted) ? att(sl, sv) : 0;
            as_r = (cs && !aborted) ? att(sr, sv) : 0;
            e.l = 24'((ap_l + as_l) * 128);
            e.r = 24'((ap_r + as_r) * 128);
            e.upcm = !aborted && !cp;
            e.upsg = !aborted && !cs;
            e.ovr  = (xo >= 0);
        end
        @(negedge clk);
        pcm_vol = pv; psg_vol = sv; enable = en;
        clr_status = 1'b1; next_sample = 1'b1;
        e.cyc = en ? cyc + m + 1 : cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        next_sample = 1'b0; clr_status = 1'b0;
        fork
            if (en) drv_src(1'b0, dp, pl, pr, (1 + dp) <= (m - 1));
            if (en) drv_src(1'b1, ds, sl, sr, (1 + ds) <= (m - 1));
            if (en && aborted) begin
                repeat (ab) @(negedge clk);
                enable = 1'b0;
            end
            if (en && xo >= 0) begin
                repeat (xo) @(negedge clk);
                next_sample = 1'b1;
                @(negedge clk);
                next_sample = 1'b0;
            end
            wait_drain();
        join
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic int pick_delay();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 6));
        return int'($urandom_range(0, TIMEOUT + 3));
    endfunction

    function automatic logic [3:0] pick_vol();
        if ($urandom_range(0, 3) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_src(1'b0, 1'b0, 16'd0, 16'd0);
        set_src(1'b1, 1'b0, 16'd0, 16'd0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk(left_data == 24'd0, "reset_left", left_data, 0);
        chk(right_data == 24'd0, "reset_right", right_data, 0);
        chk(!ifc.pcm_ready && !ifc.psg_ready, "reset_ready", {ifc.pcm_ready, ifc.psg_ready}, 0);
        chk(!sample_done, "reset_done", sample_done, 0);
        chk(!underrun_pcm && !underrun_psg && !overrun, "reset_flags",
            {underrun_pcm, underrun_psg, overrun}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        period(1, 0, 0, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 4'd0, 4'd0, -1, -1);
        period(1, 0, 0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 4'd0, 4'd0, -1, -1);
        period(1, 0, 0, 16'h1000, 16'hF001, 16'h1234, 16'h4321, 4'd1, 4'd15, -1, -1);
        period(1, 0, 0, 16'h1000, 16'h2000, 16'h0800, 16'h0000, 4'd15, 4'd15, -1, -1);
        period(1, 0, 999, 16'h1000, 16'h0000, 16'h7777, 16'h0000, 4'd0, 4'd0, -1, -1);
        chk(underrun_psg, "underrun_sticky", underrun_psg, 1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk(!underrun_psg, "underrun_clear", underrun_psg, 0);
        period(1, 0, 9, 16'h0123, 16'hFEDC, 16'h0456, 16'h8001, 4'd0, 4'd2, -1, -1);
        period(1, 0, 5, 16'h2000, 16'h0100, 16'h1000, 16'hFFFF, 4'd3, 4'd0, -1, 2);
        period(1, 999, 999, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'd0, 4'd0, 3, -1);
        period(0, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'd0, 4'd0, -1, -1);
        period(1, 0, TIMEOUT - 1, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 4'd14, 4'd0, -1, -1);

        for (int i = 0; i < 60; i++) begin
            period(($urandom_range(0, 9) != 0), pick_delay(), pick_delay(),
                   16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   pick_vol(), pick_vol(),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT)) : -1,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        // Reset mid-COLLECT with nonzero outputs and a set flag beforehand
        period(1, 0, 999, 16'h1000, 16'h0400, 16'h0000, 16'h0000, 4'd0, 4'd0, -1, -1);
        @(negedge clk);
        next_sample = 1'b1;
        @(negedge clk);
        next_sample = 1'b0;
        repeat (2) @(negedge clk);
        chk(ifc.pcm_ready, "collect_before_reset", ifc.pcm_ready, 1);
        rst_n = 1'b0;
        #1;
        chk(left_data == 24'd0, "midreset_left", left_data, 0);
        chk(right_data == 24'd0, "midreset_right", right_data, 0);
        chk(!ifc.pcm_ready && !ifc.psg_ready, "midreset_ready", {ifc.pcm_ready, ifc.psg_ready}, 0);
        chk(!underrun_psg && !underrun_pcm && !overrun, "midreset_flags",
            {underrun_pcm, underrun_psg, overrun}, 0);
        chk(!sample_done, "midreset_done", sample_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 4) @(negedge clk);
        chk(left_data == 24'd0, "no_partial_output", left_data, 0);
        period(1, 0, 0, 16'h1000, 16'h0000, 16'h0800, 16'h0000, 4'd0, 4'd0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
